// File: rtl/ga23_pkg.sv
// ---------------------------------------------------------------------------
// ga23_pkg
//   Shared types and constants for the GA23 tilemap SDRAM read path.
//   NUM_LAYERS  : number of tilemap layer fetchers sharing the SDRAM port
//   SDR_ADDR_W  : SDRAM word address width
//   sdr_addr_t  : SDRAM word address
//   arb_state_t : arbiter FSM state (IDLE: free to grant, WAIT: read outstanding)
//   idx_width() : width of an index into n requesters (at least 1 bit)
// ---------------------------------------------------------------------------
package ga23_pkg;

    localparam int NUM_LAYERS = 3;
    localparam int SDR_ADDR_W = 22;

    typedef logic [SDR_ADDR_W-1:0] sdr_addr_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ga23_rr_pick.sv
// ---------------------------------------------------------------------------
// ga23_rr_pick
//   Combinational round-robin picker. Scans the pending flags starting at the
//   round-robin pointer and wrapping, and returns the first set requester.
// Ports
//   i_pend  in   NUM_REQ  pending flag per requester
//   i_rr    in   IDX_W    requester to consider first
//   o_valid out  1        at least one requester pending
//   o_gnt   out  IDX_W    selected requester (0 when o_valid is low)
// ---------------------------------------------------------------------------
module ga23_rr_pick
    import ga23_pkg::*;
#(
    parameter int NUM_REQ = NUM_LAYERS,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_pend,
    input  logic [IDX_W-1:0]   i_rr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_gnt
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_valid = 1'b0;
        o_gnt   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // requester rr+k, wrapped back into 0..NUM_REQ-1
            w_idx = IDX_W'((32'(i_rr) + k) % NUM_REQ);
            if (!o_valid && i_pend[w_idx]) begin
                o_valid = 1'b1;
                o_gnt   = w_idx;
            end
        end
    end

endmodule

// File: rtl/ga23_sdr_arbiter.sv
// ---------------------------------------------------------------------------
// ga23_sdr_arbiter
//   Shares one SDRAM tile-row read port between NUM_REQ tilemap layer
//   fetchers. Requests are latched per layer (newest address wins), granted
//   round-robin, and only one read is outstanding at a time. Each returned row
//   goes back to its layer with a one-cycle ready pulse, unless the layer has
//   already asked for a newer row, in which case it is dropped and counted.
//   A read with no completion after TIMEOUT cycles is abandoned.
// Ports
//   clk       in   1               system clock, rising edge
//   reset_n   in   1               asynchronous active-low reset
//   req       in   NUM_REQ         one-cycle request pulse per layer
//   req_addr  in   NUM_REQ*ADDR_W  per-layer row address, sampled with req
//   rsp_data  out  NUM_REQ*32      per-layer returned row, held between deliveries
//   rsp_rdy   out  NUM_REQ         one-cycle pulse: matching rsp_data slice updated
//   mem_req   out  1               one-cycle read strobe to SDRAM controller
//   mem_addr  out  ADDR_W          read address, stable from mem_req to mem_rdy
//   mem_data  in   32              read data, valid with mem_rdy
//   mem_rdy   in   1               one-cycle read-complete pulse
//   timeout   out  1               sticky: a read has timed out
//   drop_cnt  out  8               saturating count of discarded rows
// ---------------------------------------------------------------------------
module ga23_sdr_arbiter
    import ga23_pkg::*;
#(
    parameter int NUM_REQ = NUM_LAYERS,
    parameter int ADDR_W  = SDR_ADDR_W,
    parameter int TIMEOUT = 63
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ*32-1:0]     rsp_data,
    output logic [NUM_REQ-1:0]        rsp_rdy,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [31:0]               mem_data,
    input  logic                      mem_rdy,
    output logic                      timeout,
    output logic [7:0]                drop_cnt
);

    localparam int         IDX_W    = idx_width(NUM_REQ);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // FSM
    arb_state_t r_state;
    arb_state_t w_state_nxt;

    // request capture
    logic [NUM_REQ-1:0] r_pend;
    logic [ADDR_W-1:0]  r_paddr [NUM_REQ];

    // arbitration / outstanding read
    logic [IDX_W-1:0]   r_rr;
    logic [IDX_W-1:0]   r_gnt;
    logic [7:0]         r_tmr;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;

    // responses and status
    logic [NUM_REQ*32-1:0] r_rsp_data;
    logic [NUM_REQ-1:0]    r_rsp_rdy;
    logic                  r_timeout;
    logic [7:0]            r_drop_cnt;

    // combinational decisions
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_pick_g;
    logic [IDX_W-1:0]   w_rr_nxt;
    logic               w_superseded;
    logic               w_tmr_expired;
    logic               w_grant;
    logic               w_deliver;
    logic               w_drop;
    logic               w_tmo;

    ga23_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_pend  (r_pend),
        .i_rr    (r_rr),
        .o_valid (w_pick_valid),
        .o_gnt   (w_pick_g)
    );

    assign w_rr_nxt = (w_pick_g == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_g + IDX_W'(1);

    // A newer request from the granted layer (already latched or arriving
    // this very cycle) makes the outstanding row stale.
    assign w_superseded  = r_pend[r_gnt] | req[r_gnt];
    assign w_tmr_expired = (r_tmr == TMO_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_pick_valid) w_state_nxt = WAIT;
            WAIT: if (mem_rdy || w_tmr_expired) w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: action decode ----------------
    always_comb begin
        w_grant   = 1'b0;
        w_deliver = 1'b0;
        w_drop    = 1'b0;
        w_tmo     = 1'b0;
        unique case (r_state)
            IDLE: w_grant = w_pick_valid;
            WAIT: begin
                if (mem_rdy) begin
                    if (w_superseded) w_drop    = 1'b1;
                    else              w_deliver = 1'b1;
                end else if (w_tmr_expired) begin
                    w_tmo  = 1'b1;
                    w_drop = 1'b1;
                end
            end
        endcase
    end

    // ---------------- request capture ----------------
    // A request arriving in the cycle its layer is granted keeps the layer
    // pending: the new address belongs to a later tile.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_paddr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    r_pend[i]  <= 1'b1;
                    r_paddr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                end else if (w_grant && (w_pick_g == IDX_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- read issue and timer ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_gnt      <= '0;
            r_rr       <= '0;
            r_tmr      <= '0;
        end else begin
            r_mem_req <= w_grant;
            if (w_grant) begin
                r_mem_addr <= r_paddr[w_pick_g];
                r_gnt      <= w_pick_g;
                r_rr       <= w_rr_nxt;
                r_tmr      <= '0;
            end else if (r_state == WAIT) begin
                r_tmr <= r_tmr + 8'd1;
            end
        end
    end

    // ---------------- responses and status ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_data <= '0;
            r_rsp_rdy  <= '0;
            r_timeout  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_rsp_rdy[i] <= w_deliver && (r_gnt == IDX_W'(i));
                if (w_deliver && (r_gnt == IDX_W'(i))) begin
                    r_rsp_data[i*32 +: 32] <= mem_data;
                end
            end
            if (w_tmo) begin
                r_timeout <= 1'b1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_rdy  = r_rsp_rdy;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign timeout  = r_timeout;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
module tb_ga23_sdr_arbiter;

    localparam int NR = 3;
    localparam int AW = 22;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*32-1:0] rsp_data;
    logic [NR-1:0]   rsp_rdy;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_data;
    logic            mem_rdy;
    logic            timeout;
    logic [7:0]      drop_cnt;

    always #5 clk = ~clk;

    ga23_sdr_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .TIMEOUT (63)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .rsp_data (rsp_data),
        .rsp_rdy  (rsp_rdy),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_rdy  (mem_rdy),
        .timeout  (timeout),
        .drop_cnt (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard: expected strobe addresses, expected outcome of each mem_rdy
    // (layer index, or -1 for a row that must be dropped)
    logic [AW-1:0] q_addr [$];
    int            q_rsp_layer [$];
    logic [31:0]   q_rsp_data [$];

    // reference model of held responses and drop counter
    logic [31:0] m_rsp [NR];
    int          m_drop;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int l, input logic [AW-1:0] a);
        req_addr[l*AW +: AW] = a;
    endtask

    task automatic pulse(input logic [NR-1:0] m);
        req = m;
        tick();
        req = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_rsp[i] = '0;
        m_drop = 0;
        q_addr.delete();
        q_rsp_layer.delete();
        q_rsp_data.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rsp_data"}, rsp_data, '0);
        check({tag, "_rsp_rdy"},  rsp_rdy,  '0);
        check({tag, "_mem_req"},  mem_req,  '0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_timeout"},  timeout,  '0);
        check({tag, "_drop_cnt"}, drop_cnt, '0);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        req     = '0;
        mem_rdy = 1'b0;
        tick();
        tick();
        model_clear();
        check_reset_vals(tag);
        reset_n = 1'b1;
        tick();
    endtask

    // Wait (bounded) for a strobe, compare against the next queued address
    // and the expected wait; a negative exp_wait skips the latency check.
    task automatic expect_strobe(input string tag, input int exp_wait);
        int w;
        logic [AW-1:0] a;
        w = 0;
        while (mem_req !== 1'b1 && w < 80) begin
            tick();
            w++;
        end
        checks++;
        assert (q_addr.size() > 0) else begin
            errors++;
            $error("FAIL %s_queue observed=empty expected=queued address", tag);
        end
        a = (q_addr.size() > 0) ? q_addr.pop_front() : '0;
        check({tag, "_seen"}, mem_req, 1'b1);
        check({tag, "_addr"}, mem_addr, a);
        if (exp_wait >= 0) check({tag, "_lat"}, w, exp_wait);
        tick();
        check({tag, "_1cyc"}, mem_req, 1'b0);
    endtask

    // Drive one mem_rdy after 'delay' cycles (optionally with requests in the
    // same cycle) and compare the next-cycle response against the scoreboard.
    task automatic mem_done(input string tag, input int delay, input logic [31:0] d,
                            input logic [NR-1:0] req_m);
        int l;
        logic [NR-1:0] exp_m;
        logic [31:0] ed;
        repeat (delay) tick();
        mem_data = d;
        mem_rdy  = 1'b1;
        req      = req_m;
        tick();
        mem_rdy  = 1'b0;
        req      = '0;
        checks++;
        assert (q_rsp_layer.size() > 0) else begin
            errors++;
            $error("FAIL %s_queue observed=empty expected=queued response", tag);
        end
        l  = (q_rsp_layer.size() > 0) ? q_rsp_layer.pop_front() : -1;
        ed = (q_rsp_data.size() > 0)  ? q_rsp_data.pop_front()  : '0;
        exp_m = '0;
        if (l >= 0) begin
            exp_m[l] = 1'b1;
            m_rsp[l] = ed;
        end else begin
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
        check({tag, "_rdy"},  rsp_rdy,  exp_m);
        check({tag, "_data"}, rsp_data, {m_rsp[2], m_rsp[1], m_rsp[0]});
        check({tag, "_drop"}, drop_cnt, m_drop);
        tick();
        check({tag, "_rdy_pulse"}, rsp_rdy, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        reset_n  = 1'b0;
        req      = '0;
        req_addr = '0;
        mem_data = '0;
        mem_rdy  = 1'b0;
        model_clear();
        do_reset("rst0");

        // single request, latency and delivery
        set_addr(1, 22'h12345);
        q_addr.push_back(22'h12345);
        pulse(3'b010);
        check("t1_n1_no_strobe", mem_req, 1'b0);
        expect_strobe("t1", 1);
        q_rsp_layer.push_back(1); q_rsp_data.push_back(32'hDEADBEEF);
        mem_done("t1", 1, 32'hDEADBEEF, '0);

        // three simultaneous requests from a fresh pointer: 0,1,2
        do_reset("rst1");
        set_addr(0, 22'h100); set_addr(1, 22'h101); set_addr(2, 22'h102);
        q_addr.push_back(22'h100); q_addr.push_back(22'h101); q_addr.push_back(22'h102);
        pulse(3'b111);
        expect_strobe("t2g0", 1);
        q_rsp_layer.push_back(0); q_rsp_data.push_back(32'hA0000000);
        mem_done("t2r0", 2, 32'hA0000000, '0);
        expect_strobe("t2g1", 0);
        q_rsp_layer.push_back(1); q_rsp_data.push_back(32'hA1111111);
        mem_done("t2r1", 2, 32'hA1111111, '0);
        expect_strobe("t2g2", 0);
        q_rsp_layer.push_back(2); q_rsp_data.push_back(32'hA2222222);
        mem_done("t2r2", 2, 32'hA2222222, '0);

        // pointer wrapped to 0: layer 0 before layer 2
        set_addr(0, 22'h200); set_addr(2, 22'h202);
        q_addr.push_back(22'h200); q_addr.push_back(22'h202);
        pulse(3'b101);
        expect_strobe("t2b_g0", 1);
        q_rsp_layer.push_back(0); q_rsp_data.push_back(32'hB0B0B0B0);
        mem_done("t2b_r0", 1, 32'hB0B0B0B0, '0);
        expect_strobe("t2b_g2", 0);
        q_rsp_layer.push_back(2); q_rsp_data.push_back(32'hB2B2B2B2);
        mem_done("t2b_r2", 1, 32'hB2B2B2B2, '0);

        // superseded row: newer request during WAIT, then one in the rdy cycle
        set_addr(2, 22'h300);
        q_addr.push_back(22'h300);
        pulse(3'b100);
        expect_strobe("t3a", 1);
        set_addr(2, 22'h301);
        pulse(3'b100);
        q_rsp_layer.push_back(-1); q_rsp_data.push_back('0);
        mem_done("t3drop1", 1, 32'h0BAD0000, '0);
        q_addr.push_back(22'h301);
        expect_strobe("t3b", 0);
        set_addr(2, 22'h302);
        q_rsp_layer.push_back(-1); q_rsp_data.push_back('0);
        mem_done("t3drop2", 1, 32'h0BAD0001, 3'b100);
        q_addr.push_back(22'h302);
        expect_strobe("t3c", 0);
        q_rsp_layer.push_back(2); q_rsp_data.push_back(32'hC2C2C2C2);
        mem_done("t3r", 1, 32'hC2C2C2C2, '0);

        // two requests from layer 0 before its grant: one strobe, newest addr
        set_addr(1, 22'h400);
        q_addr.push_back(22'h400);
        pulse(3'b010);
        expect_strobe("t4a", 1);
        set_addr(0, 22'h401);
        pulse(3'b001);
        set_addr(0, 22'h402);
        pulse(3'b001);
        q_rsp_layer.push_back(1); q_rsp_data.push_back(32'hD1D1D1D1);
        mem_done("t4r1", 1, 32'hD1D1D1D1, '0);
        q_addr.push_back(22'h402);
        expect_strobe("t4b", 0);
        q_rsp_layer.push_back(0); q_rsp_data.push_back(32'hD0D0D0D0);
        mem_done("t4r0", 1, 32'hD0D0D0D0, '0);
        seen = 1'b0;
        repeat (6) begin
            if (mem_req === 1'b1) seen = 1'b1;
            tick();
        end
        check("t4_single_strobe", seen, 1'b0);

        // timeout: strobe at S, abandoned after 63 WAIT cycles, next grant at S+64
        set_addr(1, 22'h500);
        q_addr.push_back(22'h500);
        pulse(3'b010);
        expect_strobe("t5a", 1);
        set_addr(0, 22'h501);
        pulse(3'b001);
        repeat (59) tick();
        check("t5_pre_timeout", timeout, 1'b0);
        check("t5_pre_drop", drop_cnt, m_drop);
        q_addr.push_back(22'h501);
        expect_strobe("t5b", 3);
        m_drop = m_drop + 1;
        check("t5_timeout", timeout, 1'b1);
        check("t5_drop", drop_cnt, m_drop);
        q_rsp_layer.push_back(0); q_rsp_data.push_back(32'hE0E0E0E0);
        mem_done("t5r", 1, 32'hE0E0E0E0, '0);
        // stray mem_rdy while IDLE is ignored
        mem_data = 32'hF00DF00D;
        mem_rdy  = 1'b1;
        tick();
        mem_rdy  = 1'b0;
        check("t5_late_rdy", rsp_rdy, '0);
        check("t5_late_data", rsp_data, {m_rsp[2], m_rsp[1], m_rsp[0]});
        check("t5_late_drop", drop_cnt, m_drop);
        tick();
        check("t5_late_no_strobe", mem_req, 1'b0);
        check("t5_sticky", timeout, 1'b1);

        // drop counter saturation
        set_addr(0, 22'h600);
        pulse(3'b001);
        for (int i = 0; i < 260; i++) begin
            q_addr.push_back(22'h600);
            expect_strobe("sat", (i == 0) ? 1 : 0);
            q_rsp_layer.push_back(-1); q_rsp_data.push_back('0);
            mem_done("sat", 0, 32'(i), 3'b001);
        end
        q_addr.push_back(22'h600);
        expect_strobe("sat_last", 0);
        q_rsp_layer.push_back(0); q_rsp_data.push_back(32'h600D600D);
        mem_done("sat_last", 0, 32'h600D600D, '0);
        check("sat_final", drop_cnt, 8'd255);

        // reset while a read is outstanding; its late completion is ignored
        set_addr(2, 22'h700);
        q_addr.push_back(22'h700);
        pulse(3'b100);
        expect_strobe("t7", 1);
        reset_n = 1'b0;
        tick();
        tick();
        model_clear();
        check_reset_vals("t7_in_reset");
        reset_n = 1'b1;
        tick();
        mem_data = 32'h77777777;
        mem_rdy  = 1'b1;
        tick();
        mem_rdy  = 1'b0;
        check_reset_vals("t7_late_rdy");
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (mem_req === 1'b1) seen = 1'b1;
        end
        check("t7_no_grant", seen, 1'b0);
        check_reset_vals("t7_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
